// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } boot_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_serializer.sv
// Holds one program word and emits it as four little-endian byte writes with
// incrementing byte addresses. Also owns the registered host-side ready.
module word_serializer
    import boot_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             i_load_en,    // words may be accepted this cycle
    input  logic             i_clear,      // restart byte addressing at 0
    input  logic             i_want_more,  // controller will want a word next cycle
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_mem_en,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_data,
    output logic             o_word_end    // current cycle drives the last byte of a word
);

    localparam logic [1:0] LAST_REM = 2'(BYTES_PER_WORD - 1);

    logic [WIDTH-1:0] r_word;
    logic [1:0]       r_rem;
    logic [WIDTH-1:0] r_next_addr;
    logic             r_ready;
    logic             r_en;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_data;

    logic [WIDTH-1:0] w_word_d;
    logic [1:0]       w_rem_d;
    logic [WIDTH-1:0] w_next_addr_d;
    logic             w_ready_d;
    logic             w_en_d;
    logic [WIDTH-1:0] w_addr_d;
    logic [WIDTH-1:0] w_data_d;
    logic             w_accept;

    assign w_accept = i_load_en && i_valid && r_ready;

    // Next byte selection: a new word emits byte 0 at once, otherwise drain the held word.
    always_comb begin
        w_word_d      = r_word;
        w_rem_d       = r_rem;
        w_next_addr_d = r_next_addr;
        w_en_d        = 1'b0;
        w_addr_d      = r_addr;
        w_data_d      = r_data;
        if (i_clear) begin
            w_next_addr_d = '0;
        end
        if (w_accept) begin
            w_word_d      = i_data;
            w_rem_d       = LAST_REM;
            w_en_d        = 1'b1;
            w_addr_d      = r_next_addr;
            w_data_d      = WIDTH'(i_data[7:0]);
            w_next_addr_d = r_next_addr + WIDTH'(1);
        end else if (r_rem != 2'd0) begin
            // Byte 1 of the held word always sits in [15:8] because the word shifts down.
            w_word_d      = r_word >> 8;
            w_rem_d       = r_rem - 2'd1;
            w_en_d        = 1'b1;
            w_addr_d      = r_next_addr;
            w_data_d      = WIDTH'(r_word[15:8]);
            w_next_addr_d = r_next_addr + WIDTH'(1);
        end
        // Ready rises on the cycle the last byte is driven, so words stream with no bubble.
        w_ready_d = i_want_more && (w_rem_d == 2'd0);
    end

    // Serializer state and registered memory-port outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_word      <= '0;
            r_rem       <= 2'd0;
            r_next_addr <= '0;
            r_ready     <= 1'b0;
            r_en        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
        end else begin
            r_word      <= w_word_d;
            r_rem       <= w_rem_d;
            r_next_addr <= w_next_addr_d;
            r_ready     <= w_ready_d;
            r_en        <= w_en_d;
            r_addr      <= w_addr_d;
            r_data      <= w_data_d;
        end
    end

    assign o_ready    = r_ready;
    assign o_mem_en   = r_en;
    assign o_mem_addr = r_addr;
    assign o_mem_data = r_data;
    assign o_word_end = r_en && (r_rem == 2'd0);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot/run controller: loads a program image into the core's byte-wide
// instruction memory, releases the core and watches for exit or timeout.
module imem_boot_ctrl
    import boot_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned IMEM_DEPTH     = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned EXIT_CODE      = 93
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inData,
    input  logic             ack,
    input  logic [WIDTH-1:0] gp,
    input  logic [WIDTH-1:0] a7,
    input  logic [WIDTH-1:0] a0,
    output logic             coreReset,
    output logic             insMemEn,
    output logic [WIDTH-1:0] insMemAddr,
    output logic [WIDTH-1:0] insMemData,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             lenErr
);

    localparam int unsigned MAX_WORDS = IMEM_DEPTH / BYTES_PER_WORD;
    localparam int unsigned WCNT_W    = $clog2(MAX_WORDS + 1);
    localparam int unsigned CYC_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    boot_state_t       r_state;
    boot_state_t       w_state_d;
    logic [WCNT_W-1:0] r_words;
    logic [WCNT_W-1:0] w_words_d;
    logic [CYC_W-1:0]  r_cycle;
    logic [CYC_W-1:0]  w_cycle_d;
    logic              r_armed;
    logic              w_armed_d;
    logic              r_core_reset;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              w_pass_d;
    logic              r_timeout;
    logic              w_timeout_d;
    logic              r_len_err;
    logic              w_len_err_d;

    logic              w_hdr_accept;
    logic              w_data_accept;
    logic              w_clear;
    logic              w_want_more;
    logic              w_word_end;
    logic              w_exit_hit;
    logic              w_time_hit;

    assign w_hdr_accept  = (r_state == IDLE) && inValid && inReady;
    assign w_data_accept = (r_state == LOAD) && inValid && inReady;
    // a7 already equal to EXIT_CODE at RUN start is stale, so only an armed run may exit.
    assign w_exit_hit    = r_armed && (a7 == WIDTH'(EXIT_CODE));
    assign w_time_hit    = (r_cycle == CYC_W'(TIMEOUT_CYCLES - 1));

    // Next-state, counters and status flags.
    always_comb begin
        w_state_d   = r_state;
        w_words_d   = r_words;
        w_cycle_d   = r_cycle;
        w_armed_d   = r_armed;
        w_pass_d    = r_pass;
        w_timeout_d = r_timeout;
        w_len_err_d = r_len_err;
        w_clear     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_hdr_accept && (inData != '0)) begin
                    if (inData > WIDTH'(MAX_WORDS)) begin
                        w_state_d   = DONE;
                        w_len_err_d = 1'b1;
                        w_pass_d    = 1'b0;
                    end else begin
                        w_state_d = LOAD;
                        w_words_d = WCNT_W'(inData);
                        w_clear   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (w_data_accept) begin
                    w_words_d = r_words - WCNT_W'(1);
                end
                // r_words hits 0 at the last accept, so the next word end is byte 4N.
                if ((r_words == '0) && w_word_end) begin
                    w_state_d = RELEASE;
                end
            end
            RELEASE: begin
                w_state_d = RUN;
                w_cycle_d = '0;
                w_armed_d = 1'b0;
            end
            RUN: begin
                w_cycle_d = r_cycle + CYC_W'(1);
                if (a7 != WIDTH'(EXIT_CODE)) begin
                    w_armed_d = 1'b1;
                end
                if (w_exit_hit) begin
                    w_state_d   = DONE;
                    w_pass_d    = (gp == WIDTH'(1)) && (a0 == '0);
                    w_timeout_d = 1'b0;
                end else if (w_time_hit) begin
                    w_state_d   = DONE;
                    w_pass_d    = 1'b0;
                    w_timeout_d = 1'b1;
                end
            end
            DONE: begin
                if (ack) begin
                    w_state_d   = IDLE;
                    w_pass_d    = 1'b0;
                    w_timeout_d = 1'b0;
                    w_len_err_d = 1'b0;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        w_want_more = (w_state_d == IDLE) || ((w_state_d == LOAD) && (w_words_d != '0));
    end

    // State register and registered status outputs derived from the next state.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state      <= IDLE;
            r_words      <= '0;
            r_cycle      <= '0;
            r_armed      <= 1'b0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_timeout    <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_words      <= w_words_d;
            r_cycle      <= w_cycle_d;
            r_armed      <= w_armed_d;
            r_core_reset <= (w_state_d != RUN);
            r_busy       <= (w_state_d == LOAD) || (w_state_d == RELEASE) || (w_state_d == RUN);
            r_done       <= (w_state_d == DONE);
            r_pass       <= w_pass_d;
            r_timeout    <= w_timeout_d;
            r_len_err    <= w_len_err_d;
        end
    end

    word_serializer #(
        .WIDTH(WIDTH)
    ) u_ser (
        .clock      (clock),
        .resetN     (resetN),
        .i_load_en  (r_state == LOAD),
        .i_clear    (w_clear),
        .i_want_more(w_want_more),
        .i_valid    (inValid),
        .i_data     (inData),
        .o_ready    (inReady),
        .o_mem_en   (insMemEn),
        .o_mem_addr (insMemAddr),
        .o_mem_data (insMemData),
        .o_word_end (w_word_end)
    );

    assign coreReset = r_core_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign lenErr    = r_len_err;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: load, exit, timeout, length error,
// streaming and asynchronous reset. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_imem_boot_ctrl;

    logic        clock;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [31:0] inData;
    logic        ack;
    logic [31:0] gp;
    logic [31:0] a7;
    logic [31:0] a0;
    logic        coreReset;
    logic        insMemEn;
    logic [31:0] insMemAddr;
    logic [31:0] insMemData;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic        lenErr;

    int checks   = 0;
    int failures = 0;

    imem_boot_ctrl #(
        .WIDTH         (32),
        .IMEM_DEPTH    (4096),
        .TIMEOUT_CYCLES(50),
        .EXIT_CODE     (93)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .inValid   (inValid),
        .inReady   (inReady),
        .inData    (inData),
        .ack       (ack),
        .gp        (gp),
        .a7        (a7),
        .a0        (a0),
        .coreReset (coreReset),
        .insMemEn  (insMemEn),
        .insMemAddr(insMemAddr),
        .insMemData(insMemData),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .lenErr    (lenErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loads two words from IDLE and returns at the falling edge of the first RUN cycle.
    task automatic load_two(input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w [2];
        w[0] = w0;
        w[1] = w1;
        check("idle_ready", 32'(inReady), 1);
        inValid = 1'b1;
        inData  = 32'd2;
        tick();
        check("load_busy", 32'(busy), 1);
        check("load_ready", 32'(inReady), 1);
        check("load_core_reset", 32'(coreReset), 1);
        check("load_no_en", 32'(insMemEn), 0);
        for (int wi = 0; wi < 2; wi++) begin
            inValid = 1'b1;
            inData  = w[wi];
            tick();
            inValid = 1'b0;
            inData  = '0;
            for (int b = 0; b < 4; b++) begin
                check("byte_en", 32'(insMemEn), 1);
                check("byte_addr", insMemAddr, 32'(wi * 4 + b));
                check("byte_data", insMemData, (w[wi] >> (8 * b)) & 32'hFF);
                check("byte_ready", 32'(inReady), 32'(b == 3 && wi == 0));
                check("byte_core_reset", 32'(coreReset), 1);
                if (b < 3) tick();
            end
        end
        tick();
        check("release_en", 32'(insMemEn), 0);
        check("release_core_reset", 32'(coreReset), 1);
        check("release_busy", 32'(busy), 1);
        tick();
        check("run_core_reset", 32'(coreReset), 0);
        check("run_busy", 32'(busy), 1);
        check("run_done", 32'(done), 0);
    endtask

    task automatic ack_done();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_done", 32'(done), 0);
        check("ack_pass", 32'(pass), 0);
        check("ack_timeout", 32'(timeout), 0);
        check("ack_len_err", 32'(lenErr), 0);
        check("ack_ready", 32'(inReady), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_core_reset"}, 32'(coreReset), 1);
        check({tag, "_ready"}, 32'(inReady), 0);
        check({tag, "_en"}, 32'(insMemEn), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_flags"}, {28'd0, pass, timeout, lenErr, 1'b0}, 0);
    endtask

    initial begin
        logic [31:0] bp [3];
        resetN  = 1'b0;
        inValid = 1'b0;
        inData  = '0;
        ack     = 1'b0;
        gp      = '0;
        a7      = '0;
        a0      = '0;

        // Reset values, ready appears on the first edge after release.
        tick();
        check_reset_values("rst");
        resetN = 1'b1;
        tick();
        check("idle_ready_after_reset", 32'(inReady), 1);
        check("idle_core_reset", 32'(coreReset), 1);

        // Load and pass.
        load_two(32'h0000_0013, 32'h0000_006F);
        tick();
        check("pass_not_yet", 32'(done), 0);
        a7 = 32'd93;
        gp = 32'd1;
        a0 = 32'd0;
        tick();
        check("pass_done", 32'(done), 1);
        check("pass_pass", 32'(pass), 1);
        check("pass_timeout", 32'(timeout), 0);
        check("pass_core_reset", 32'(coreReset), 1);
        check("pass_ready", 32'(inReady), 0);
        check("pass_busy", 32'(busy), 0);
        tick();
        check("pass_hold", {30'd0, done, pass}, 32'h3);
        ack_done();
        a7 = '0;

        // Fail exit.
        load_two(32'h1122_3344, 32'h5566_7788);
        tick();
        a7 = 32'd93;
        gp = 32'd3;
        tick();
        check("fail_done", 32'(done), 1);
        check("fail_pass", 32'(pass), 0);
        check("fail_timeout", 32'(timeout), 0);
        ack_done();
        a7 = '0;
        gp = '0;

        // Timeout with a7 held at 0.
        load_two(32'hA5A5_5A5A, 32'h0F0F_F0F0);
        repeat (49) tick();
        check("to_not_early", 32'(done), 0);
        check("to_still_running", 32'(coreReset), 0);
        tick();
        check("to_done", 32'(done), 1);
        check("to_timeout", 32'(timeout), 1);
        check("to_pass", 32'(pass), 0);
        ack_done();

        // Stale exit code present from RUN start must never arm.
        a7 = 32'd93;
        gp = 32'd1;
        load_two(32'h0000_0001, 32'h0000_0002);
        repeat (49) tick();
        check("stale_not_early", 32'(done), 0);
        tick();
        check("stale_timeout", 32'(timeout), 1);
        check("stale_pass", 32'(pass), 0);
        ack_done();

        // Exit and timeout in the same cycle: exit wins.
        a7 = '0;
        load_two(32'h0000_0003, 32'h0000_0004);
        repeat (49) tick();
        check("tie_not_early", 32'(done), 0);
        a7 = 32'd93;
        tick();
        check("tie_done", 32'(done), 1);
        check("tie_pass", 32'(pass), 1);
        check("tie_timeout", 32'(timeout), 0);
        ack_done();
        a7 = '0;
        gp = '0;

        // Length error, then header 0, then the largest legal header.
        inValid = 1'b1;
        inData  = 32'd1025;
        tick();
        inValid = 1'b0;
        check("len_done", 32'(done), 1);
        check("len_err", 32'(lenErr), 1);
        check("len_pass", 32'(pass), 0);
        check("len_no_en", 32'(insMemEn), 0);
        check("len_ready", 32'(inReady), 0);
        tick();
        check("len_no_en_later", 32'(insMemEn), 0);
        ack_done();
        inValid = 1'b1;
        inData  = 32'd0;
        tick();
        inValid = 1'b0;
        check("hdr0_ready", 32'(inReady), 1);
        check("hdr0_busy", 32'(busy), 0);
        check("hdr0_done", 32'(done), 0);
        inValid = 1'b1;
        inData  = 32'd1024;
        tick();
        inValid = 1'b0;
        check("hdr_max_busy", 32'(busy), 1);
        check("hdr_max_len_err", 32'(lenErr), 0);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();

        // Backpressure: valid held high over three words.
        bp[0] = 32'h4433_2211;
        bp[1] = 32'h8877_6655;
        bp[2] = 32'hCCBB_AA99;
        inValid = 1'b1;
        inData  = 32'd3;
        tick();
        for (int k = 0; k <= 12; k++) begin
            check("bp_ready", 32'(inReady), 32'((k % 4 == 0) && (k <= 8)));
            if (k >= 1) begin
                check("bp_en", 32'(insMemEn), 1);
                check("bp_addr", insMemAddr, 32'(k - 1));
                check("bp_data", insMemData, (bp[(k - 1) / 4] >> (8 * ((k - 1) % 4))) & 32'hFF);
            end
            if (k % 4 == 0 && k <= 8) inData = bp[k / 4];
            tick();
        end
        inValid = 1'b0;
        check("bp_release_en", 32'(insMemEn), 0);
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();

        // Reset mid-load after byte 5, then a fresh load from address 0.
        inValid = 1'b1;
        inData  = 32'd2;
        tick();
        inData = 32'h0302_0100;
        tick();
        inData = 32'h0706_0504;
        repeat (5) tick();
        check("mid_addr", insMemAddr, 32'd5);
        check("mid_data", insMemData, 32'h05);
        resetN = 1'b0;
        #1;
        check_reset_values("mid_rst");
        inValid = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        check("fresh_ready", 32'(inReady), 1);
        inValid = 1'b1;
        inData  = 32'd1;
        tick();
        inData = 32'hDEAD_BEEF;
        tick();
        inValid = 1'b0;
        check("fresh_en", 32'(insMemEn), 1);
        check("fresh_addr", insMemAddr, 32'd0);
        check("fresh_data", insMemData, 32'hEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot and run controller for the single-cycle RV32 `processor` core. It accepts a program image as a stream of 32-bit words over a valid/ready handshake and serializes each word into the core's byte-wide instruction-memory write port. It holds the core in reset while loading, then releases it and watches the verification taps `gp`/`a7`/`a0` for the exit convention or a cycle timeout. It sits between the testbench/host link and the core.

## Interface
- `WIDTH`, 32, datapath and word width
- `IMEM_DEPTH`, 4096, instruction memory size in bytes; maximum program is `IMEM_DEPTH/4` words
- `TIMEOUT_CYCLES`, 100000, maximum RUN cycles before forced stop
- `EXIT_CODE`, 93, `a7` value signalling program end
- `clock`  in  1  single clock, rising edge
- `resetN`  in  1  asynchronous, active-low reset
- `inValid`  in  1  host word valid
- `inReady`  out  1  controller can take a word
- `inData`  in  WIDTH  header or program word, little-endian
- `ack`  in  1  acknowledges DONE and returns the controller to IDLE
- `gp`, `a7`, `a0`  in  WIDTH  core verification taps
- `coreReset`  out  1  synchronous active-high reset to the core
- `insMemEn`  out  1  instruction-memory write enable
- `insMemAddr`  out  WIDTH  byte address
- `insMemData`  out  WIDTH  byte in `[7:0]`; upper bits are zero
- `busy`  out  1  controller is in LOAD, RELEASE or RUN
- `done`, `pass`, `timeout`, `lenErr`  out  1  status flags, held in DONE

## Operation
- States: IDLE → LOAD → RELEASE → RUN → DONE → IDLE.
- **IDLE**
  - `inReady`=1 and `coreReset`=1.
  - A handshake word is the header N, the word count.
  - N=0: header is ignored; controller stays in IDLE.
  - N>`IMEM_DEPTH/4`: go to DONE with `lenErr`=1 and `pass`=0.
  - Otherwise: clear the address to 0, load N, go to LOAD.
- **LOAD**
  - Each accepted word is driven as 4 consecutive byte writes: bytes 0..3 at address `base+0..3`, with `insMemEn`=1 on each.
  - `coreReset`=1 throughout.
  - After the 4N-th byte, go to RELEASE.
- **RELEASE**
  - One cycle with `insMemEn`=0 and `coreReset`=1, so the core's PC is 0 on entry to RUN.
- **RUN**
  - `coreReset`=0; the cycle counter increments from 0.
  - Completion is armed once `a7`≠`EXIT_CODE` has been sampled in RUN, because the core registers are not reset.
  - Armed and `a7`==`EXIT_CODE`: go to DONE with `pass`=(`gp`==1 && `a0`==0).
  - Counter reaches `TIMEOUT_CYCLES`-1: go to DONE with `timeout`=1.
  - If both events occur in the same cycle, the exit wins.
- **DONE**
  - `done`=1 and `coreReset`=1; the flags hold.
  - `ack`=1 clears all flags and returns to IDLE.
  - `ack` is ignored in every other state.
- `inReady`=0 in RELEASE, RUN and DONE.

## Timing
- All outputs are registered.
- Reset values: `coreReset`=1, `inReady`=0 on the first edge and then 1 in IDLE; all other outputs are 0.
- Asserting `resetN` at any point (mid-load or mid-run) immediately forces IDLE and those reset values. Partial memory contents are left as-is.
- A word accepted at edge t drives bytes on cycles t+1..t+4.
- `inReady` is 1 while no word is held and on the cycle byte 3 is driven. This gives back-to-back throughput of 4 cycles/word with no bubble.
- Header-to-first-byte latency is 1 cycle after the first data handshake.
- Byte address never wraps: the header check bounds it to `IMEM_DEPTH`-1.
- Exit detection latency: DONE is entered on the edge after `a7` matches.

## Structure
- Package `boot_pkg`:
  - state enum `boot_state_t` {IDLE, LOAD, RELEASE, RUN, DONE}
  - localparam `BYTES_PER_WORD`=4
- Sub-module `word_serializer`: holds one word, emits 4 bytes with an address increment, and provides the `inReady` handshake logic.
- The top level holds the FSM, word counter, RUN counter and arming flag.

## Test plan
- **Load and pass.** Header 2, words 0x00000013, 0x0000006F → bytes 13,00,00,00,6F,00,00,00 at addresses 0..7. Then one RELEASE cycle, then RUN. With the model driving `a7`=0 and then `a7`=93, `gp`=1, `a0`=0 → `done`=1, `pass`=1.
- **Fail.** Same flow, but exit with `gp`=3 → `done`=1, `pass`=0, `timeout`=0.
- **Timeout.** `TIMEOUT_CYCLES`=50, `a7` held at 0 → `timeout`=1 exactly 50 cycles after entering RUN. Also check that a stale `a7`=93 from RUN start never arms.
- **Length error.** Header 1025 (with `IMEM_DEPTH`=4096) → DONE, `lenErr`=1, no `insMemEn` pulse. Header 0 → stays IDLE with `inReady`=1.
- **Backpressure.** `inValid` continuously high over 3 words → `inReady` duty is 1 of every 4 cycles. Zero-gap byte stream, addresses 0..11.
- **Reset mid-load.** `resetN` low after byte 5 → outputs return to reset values asynchronously. A fresh header is accepted from address 0.
